// File: rtl/gpu_mem_pkg.sv
// Shared pROM access types and default geometry for the GPU memory path.
package gpu_mem_pkg;

    localparam int PROM_ADDR_W = 16;
    localparam int PROM_DATA_W = 8;
    localparam int PROM_LAT    = 2;

    // Wide enough for any burst limit in 1..255.
    localparam int BURST_W     = 8;

    typedef struct packed {
        logic valid;
        logic port;
    } rd_tag_t;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

endpackage

// File: rtl/rd_tag_pipe.sv
// LAT-deep shift register of read tags. Each entry records whether a read was
// issued and which port issued it. A port 0 flush kills every port 0 entry
// in flight, including the one being loaded. Port 1 entries are left alone.
module rd_tag_pipe
    import gpu_mem_pkg::*;
#(
    parameter int LAT = PROM_LAT
) (
    input  logic    clk,
    input  logic    rst,
    input  rd_tag_t i_tag,
    input  logic    i_flush0,
    output rd_tag_t o_tag
);

    rd_tag_t r_stage [LAT];

    function automatic rd_tag_t flush_mask(input rd_tag_t t, input logic f);
        rd_tag_t m;
        m = t;
        if (f && (t.port == 1'b0)) begin
            m.valid = 1'b0;
        end
        return m;
    endfunction

    // Shift the tags one stage per cycle and drop port 0 entries on a flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LAT; k++) begin
                r_stage[k] <= '0;
            end
        end else begin
            r_stage[0] <= flush_mask(i_tag, i_flush0);
            for (int k = 1; k < LAT; k++) begin
                r_stage[k] <= flush_mask(r_stage[k-1], i_flush0);
            end
        end
    end

    assign o_tag = r_stage[LAT-1];

endmodule

// File: rtl/prom_arbiter.sv
// Two-port read arbiter in front of the single-port pROM. Port 0 is the pixel
// stream and port 1 is a secondary fetcher. The arbiter uses round-robin with
// bounded bursts. A tag pipeline steers returned data back to the port that
// issued the read.
module prom_arbiter
    import gpu_mem_pkg::*;
#(
    parameter int ADDR_W = PROM_ADDR_W,
    parameter int DATA_W = PROM_DATA_W,
    parameter int LAT    = PROM_LAT,
    parameter int BURST  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req0,
    input  logic [ADDR_W-1:0] i_addr0,
    output logic              o_gnt0,
    output logic              o_rvalid0,
    input  logic              i_flush0,
    input  logic              i_req1,
    input  logic [ADDR_W-1:0] i_addr1,
    output logic              o_gnt1,
    output logic              o_rvalid1,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_prom_ce,
    output logic [ADDR_W-1:0] o_prom_ad,
    input  logic [DATA_W-1:0] i_prom_dout
);

    localparam logic [BURST_W-1:0] BURST_C = BURST_W'(BURST);

    port_e              r_owner;
    port_e              w_owner_nxt;
    logic [BURST_W-1:0] r_burst;
    logic [BURST_W-1:0] w_burst_nxt;
    port_e              w_win;
    logic               w_req0;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_gnt_any;
    rd_tag_t            w_tag_in;
    rd_tag_t            w_tag_out;
    logic               w_rv0;
    logic               w_rv1;
    logic [DATA_W-1:0]  r_rdata;

    // Grant decision. A zero burst count means no run is in progress, for
    // example after reset or an idle cycle. In that case a tie goes to the
    // port that is not the owner. With owner=PORT1 out of reset, port 0 wins
    // the first tie.
    always_comb begin
        w_req0 = i_req0 & ~i_flush0;
        w_win  = PORT0;
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst) begin
            if (w_req0 && i_req1) begin
                if ((r_burst != '0) && (r_burst < BURST_C)) begin
                    w_win = r_owner;
                end else begin
                    w_win = (r_owner == PORT0) ? PORT1 : PORT0;
                end
                w_gnt0 = (w_win == PORT0);
                w_gnt1 = (w_win == PORT1);
            end else if (w_req0) begin
                w_win  = PORT0;
                w_gnt0 = 1'b1;
            end else if (i_req1) begin
                w_win  = PORT1;
                w_gnt1 = 1'b1;
            end
        end
    end

    assign w_gnt_any = w_gnt0 | w_gnt1;

    // Ownership and burst bookkeeping for the next cycle.
    always_comb begin
        w_owner_nxt = r_owner;
        w_burst_nxt = '0;
        if (w_gnt_any) begin
            if (w_win == r_owner) begin
                w_burst_nxt = (r_burst >= BURST_C) ? BURST_C : r_burst + 1'b1;
            end else begin
                w_owner_nxt = w_win;
                w_burst_nxt = BURST_W'(1);
            end
        end
    end

    // Ownership state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= PORT1;
            r_burst <= '0;
        end else begin
            r_owner <= w_owner_nxt;
            r_burst <= w_burst_nxt;
        end
    end

    assign o_gnt0    = w_gnt0;
    assign o_gnt1    = w_gnt1;
    assign o_prom_ce = w_gnt_any;
    assign o_prom_ad = w_gnt0 ? i_addr0 : (w_gnt1 ? i_addr1 : '0);

    assign w_tag_in = '{valid: w_gnt_any, port: w_gnt1};

    rd_tag_pipe #(
        .LAT (LAT)
    ) u_tag_pipe (
        .clk      (clk),
        .rst      (rst),
        .i_tag    (w_tag_in),
        .i_flush0 (i_flush0),
        .o_tag    (w_tag_out)
    );

    // A flush in the same cycle also suppresses a port 0 return that is
    // already at the last stage.
    assign w_rv0 = ~rst & w_tag_out.valid & ~w_tag_out.port & ~i_flush0;
    assign w_rv1 = ~rst & w_tag_out.valid &  w_tag_out.port;

    // Keep the last delivered word so o_rdata is stable between returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (w_rv0 | w_rv1) begin
            r_rdata <= i_prom_dout;
        end
    end

    assign o_rvalid0 = w_rv0;
    assign o_rvalid1 = w_rv1;
    assign o_rdata   = rst ? '0 : ((w_rv0 | w_rv1) ? i_prom_dout : r_rdata);

endmodule

// File: tb/tb_prom_arbiter.sv
// Scoreboard bench for prom_arbiter. The stimulus side predicts grants from
// the arbitration rules and queues the expected returns. A monitor pops and
// compares the queue whenever the DUT returns data.
module tb_prom_arbiter;

    localparam int AW    = 16;
    localparam int DW    = 8;
    localparam int LAT   = 2;
    localparam int BURST = 8;

    logic          clk    = 1'b0;
    logic          rst    = 1'b1;
    logic          req0   = 1'b0;
    logic          req1   = 1'b0;
    logic          flush0 = 1'b0;
    logic [AW-1:0] addr0  = '0;
    logic [AW-1:0] addr1  = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, prom_ce;
    logic [DW-1:0] rdata;
    logic [AW-1:0] prom_ad;
    logic [DW-1:0] prom_d1   = '0;
    logic [DW-1:0] prom_dout = '0;

    typedef struct {
        int            port;
        int            due;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc      = 0;
    int            m_owner  = 1;
    int            m_run    = 0;
    logic [DW-1:0] last_data = '0;

    always #5 clk = ~clk;

    prom_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .LAT    (LAT),
        .BURST  (BURST)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req0      (req0),
        .i_addr0     (addr0),
        .o_gnt0      (gnt0),
        .o_rvalid0   (rvalid0),
        .i_flush0    (flush0),
        .i_req1      (req1),
        .i_addr1     (addr1),
        .o_gnt1      (gnt1),
        .o_rvalid1   (rvalid1),
        .o_rdata     (rdata),
        .o_prom_ce   (prom_ce),
        .o_prom_ad   (prom_ad),
        .i_prom_dout (prom_dout)
    );

    function automatic logic [DW-1:0] prom_f(input logic [AW-1:0] a);
        return DW'((32'(a) * 73) >> 3) ^ 8'h5C ^ a[15:8];
    endfunction

    // pROM model: address in cycle t, data visible in cycle t+2.
    always @(posedge clk) begin
        prom_d1   <= prom_f(prom_ad);
        prom_dout <= prom_d1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, check grants, update model and scoreboard.
    task automatic step(input logic r0, input logic [AW-1:0] a0, input logic r1,
                        input logic [AW-1:0] a1, input logic f0, input logic rs,
                        output int win);
        logic q0;
        exp_t keep[$];
        @(posedge clk);
        #1;
        req0 = r0; addr0 = a0; req1 = r1; addr1 = a1; flush0 = f0; rst = rs;
        #2;
        win = -1;
        q0  = r0 && !f0;
        if (!rs) begin
            if (q0 && r1) win = (m_run > 0 && m_run < BURST) ? m_owner : 1 - m_owner;
            else if (q0)  win = 0;
            else if (r1)  win = 1;
        end
        chk("gnt0", 32'(gnt0), 32'(win == 0));
        chk("gnt1", 32'(gnt1), 32'(win == 1));
        chk("prom_ce", 32'(prom_ce), 32'(win >= 0));
        chk("prom_ad", 32'(prom_ad), (win == 0) ? 32'(a0) : (win == 1) ? 32'(a1) : 32'd0);
        if (rs) begin
            sb.delete();
            m_owner = 1;
            m_run   = 0;
        end else begin
            if (f0) begin
                foreach (sb[i]) if (sb[i].port != 0) keep.push_back(sb[i]);
                sb = keep;
            end
            if (win >= 0) sb.push_back('{win, cyc + LAT, prom_f(win == 0 ? a0 : a1)});
            if (win < 0)             m_run = 0;
            else if (win == m_owner) m_run = (m_run < BURST) ? m_run + 1 : BURST;
            else begin
                m_owner = win;
                m_run   = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        int w;
        repeat (n) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, w);
    endtask

    // Return-side checker, sampled on the falling edge.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rvalid in reset", 32'({rvalid1, rvalid0}), 32'd0);
                chk("rdata in reset", 32'(rdata), 32'd0);
                last_data = '0;
            end else if (rvalid0 || rvalid1) begin
                if (sb.size() == 0) begin
                    chk("unexpected rvalid", 32'({rvalid1, rvalid0}), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rvalid timing", 32'(cyc), 32'(e.due));
                    chk("rvalid port", 32'({rvalid1, rvalid0}), (e.port == 1) ? 32'd2 : 32'd1);
                    chk("rdata", 32'(rdata), 32'(e.data));
                    last_data = e.data;
                end
            end else begin
                chk("rdata hold", 32'(rdata), 32'(last_data));
                if (sb.size() > 0 && sb[0].due <= cyc) begin
                    chk("missing rvalid", 32'(rvalid0 | rvalid1), 32'd1);
                    void'(sb.pop_front());
                end
            end
        end
    endtask

    initial begin
        fork
            monitor();
            begin
                int w;
                logic r0, r1, f0, rs;
                repeat (3) step(1'b1, 16'h0100, 1'b1, 16'h0200, 1'b0, 1'b1, w);
                for (int i = 0; i < 24; i++) begin
                    step(1'b1, 16'(16'h0100 + i), 1'b1, 16'(16'h0200 + i), 1'b0, 1'b0, w);
                    chk("burst pattern", 32'(gnt1), 32'((i / 8) % 2 == 1));
                end
                idle(4);
                for (int i = 0; i < 3; i++) step(1'b1, 16'(10 + i), 1'b0, '0, 1'b0, 1'b0, w);
                idle(4);
                step(1'b0, '0, 1'b1, 16'h0033, 1'b0, 1'b0, w);
                step(1'b1, 16'h0044, 1'b0, '0, 1'b0, 1'b0, w);
                chk("no hold without contention", 32'(gnt0), 32'd1);
                idle(4);
                step(1'b1, 16'd20, 1'b0, '0, 1'b0, 1'b0, w);
                step(1'b0, '0, 1'b1, 16'h0055, 1'b0, 1'b0, w);
                step(1'b1, 16'd22, 1'b1, 16'h0056, 1'b1, 1'b0, w);
                idle(4);
                step(1'b1, 16'h0077, 1'b0, '0, 1'b0, 1'b0, w);
                step(1'b0, '0, 1'b1, 16'h0088, 1'b0, 1'b0, w);
                step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, w);
                idle(3);
                step(1'b1, 16'h0099, 1'b1, 16'h00AA, 1'b0, 1'b0, w);
                chk("priority after reset", 32'(gnt0), 32'd1);
                for (int i = 0; i < 4000; i++) begin
                    r0 = ($urandom_range(0, 99) < 80);
                    r1 = ($urandom_range(0, 99) < 65);
                    f0 = ($urandom_range(0, 99) < 4);
                    rs = ($urandom_range(0, 299) == 0);
                    step(r0, 16'($urandom), r1, 16'($urandom), f0, rs, w);
                end
                idle(6);
                chk("scoreboard drained", 32'(sb.size()), 32'd0);
                $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
                $finish;
            end
        join
    end

endmodule
